// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_pkg
//  Description : Operation and state encodings shared by the multiply/divide
//                unit and its divide datapath, plus small op-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

    // md_op encodings (3 bits)
    localparam logic [2:0] c_md_nop   = 3'd0;
    localparam logic [2:0] c_md_mult  = 3'd1;
    localparam logic [2:0] c_md_multu = 3'd2;
    localparam logic [2:0] c_md_div   = 3'd3;
    localparam logic [2:0] c_md_divu  = 3'd4;
    localparam logic [2:0] c_md_mthi  = 3'd5;
    localparam logic [2:0] c_md_mtlo  = 3'd6;

    // FSM state encodings
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_iter = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;

    // True for the multi-cycle arithmetic ops (MULT..DIVU)
    function automatic logic is_md_arith(input logic [2:0] op);
        return (op == c_md_mult) || (op == c_md_multu) ||
               (op == c_md_div)  || (op == c_md_divu);
    endfunction

    // True for ops that interpret operands as two's complement
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == c_md_mult) || (op == c_md_div);
    endfunction

    // True for the divide ops
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == c_md_div) || (op == c_md_divu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : md_div_iter
//  Description : Radix-2 restoring divide datapath on unsigned magnitudes.
//                One quotient bit per enabled cycle; WIDTH steps per divide.
//                A zero divisor yields quotient all ones, remainder=dividend.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_div_iter
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dsor;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Trial subtract of the divisor from the remainder shifted by one dividend bit
    always_comb begin
        w_shift = {r_rem, r_quot[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_dsor};
    end

    // Load operands, then keep the difference or restore on each enabled step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dsor <= '0;
        end else if (i_load) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_dsor <= i_divisor;
        end else if (i_en) begin
            if (!w_diff[WIDTH]) begin
                r_rem  <= w_diff[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_rem  = r_rem;
    assign o_quot = r_quot;

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative multiply/divide unit with HI/LO registers.
//                IDLE -> ITER (WIDTH cycles) -> FIX (sign correction and
//                HI/LO write) -> IDLE. MTHI/MTLO write in a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_is_div;
    logic               r_neg;
    logic               r_sign_a;
    logic               r_dz;

    logic               w_idle_req;
    logic               w_accept;
    logic               w_step;
    logic               w_fix_write;
    logic               w_sgn;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_psum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;

    // Request decode, operand magnitudes and shift-add / fix-up arithmetic
    always_comb begin
        w_idle_req  = (r_state == c_st_idle) && start && !flush;
        w_accept    = w_idle_req && is_md_arith(md_op);
        w_step      = (r_state == c_st_iter) && !flush;
        w_fix_write = (r_state == c_st_fix) && !flush;
        w_sgn       = is_signed_op(md_op);
        w_sa        = w_sgn && A[WIDTH-1];
        w_sb        = w_sgn && B[WIDTH-1];
        w_mag_a     = w_sa ? -A : A;
        w_mag_b     = w_sb ? -B : B;
        // Add the multiplicand into the upper half when the current multiplier bit is set
        w_psum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_prod_next = r_prod[0] ? {w_psum, r_prod[WIDTH-1:1]}
                                : {1'b0, r_prod[2*WIDTH-1:1]};
        w_prod_fix  = r_neg ? -r_prod : r_prod;
        // Divide by zero leaves the datapath with remainder=|A|; the sign fix restores A
        w_div_lo    = r_dz ? {WIDTH{1'b1}} : (r_neg ? -w_quot : w_quot);
        w_div_hi    = r_sign_a ? -w_rem : w_rem;
    end

    md_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_en       (w_step && r_is_div),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_rem      (w_rem),
        .o_quot     (w_quot)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (w_accept) w_next_state = c_st_iter;
                c_st_iter: if (r_cnt == c_cnt_last) w_next_state = c_st_fix;
                c_st_fix:  w_next_state = c_st_idle;
                default:   w_next_state = c_st_idle;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy = (r_state != c_st_idle);
    end

    // Iteration counter, operand latches, multiply product, HI/LO and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_sign_a <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= w_fix_write;

            if (flush || r_state != c_st_iter || r_cnt == c_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_fix_write) begin
                if (r_is_div) begin
                    r_hi <= w_div_hi;
                    r_lo <= w_div_lo;
                end else begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end else if (w_idle_req && md_op == c_md_mthi) begin
                r_hi <= A;
            end else if (w_idle_req && md_op == c_md_mtlo) begin
                r_lo <= A;
            end

            if (w_accept) begin
                r_mcand  <= w_mag_a;
                r_prod   <= {{WIDTH{1'b0}}, w_mag_b};
                r_is_div <= is_div_op(md_op);
                r_neg    <= w_sa ^ w_sb;
                r_sign_a <= w_sa;
                r_dz     <= is_div_op(md_op) && (B == '0);
            end else if (w_step && !r_is_div) begin
                r_prod <= w_prod_next;
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
